// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, falling-edge start detect, mid-bit sampling,
// one-cycle strobes for good bytes and framing errors.
module uart_rx #(
    parameter int unsigned BAUD = 1_000_000,
    parameter int unsigned FCLK = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err,
    output logic       rx_idle
);

    localparam int unsigned CBIT  = FCLK / BAUD;
    localparam int unsigned CNT_W = $clog2(CBIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CBIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CBIT / 2 - 1);

    generate
        if (CBIT < 4) begin : g_cbit_check
            $error("uart_rx: FCLK/BAUD must be at least 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t           state_q, state_d;
    logic             rx_meta, rx_s, rx_prev;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [7:0]       data_d;
    logic             valid_d, err_d;
    logic             fall;

    assign fall = rx_prev & ~rx_s;

    // State, counters, synchroniser and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta      <= 1'b1;
            rx_s         <= 1'b1;
            rx_prev      <= 1'b1;
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shreg_q      <= '0;
            rx_data      <= 8'h00;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_idle      <= 1'b1;
        end else begin
            rx_meta      <= rx;
            rx_s         <= rx_meta;
            rx_prev      <= rx_s;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shreg_q      <= shreg_d;
            rx_data      <= data_d;
            rx_valid     <= valid_d;
            rx_frame_err <= err_d;
            rx_idle      <= (state_d == IDLE);
        end
    end

    // Next-state and output decode; cnt restarts on every state change
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        data_d    = rx_data;
        valid_d   = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (fall) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        state_d   = DATA;
                        bit_idx_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d              = '0;
                    shreg_d[bit_idx_q] = rx_s;
                    bit_idx_d          = bit_idx_q + 1'b1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                // Leaving at mid-stop leaves half a bit to catch a back-to-back start edge
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (rx_s) begin
                        data_d  = shreg_q;
                        valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: bit-banged serial frames against a frame-level
// scoreboard (expected byte / framing error / strobe latency).
module tb_uart_rx;

    localparam int unsigned CBIT = 50;
    localparam int unsigned LAT  = 2 + CBIT / 2 + 9 * CBIT;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_idle;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    int unsigned cyc         = 0;
    logic [7:0]  last_good   = 8'h00;

    typedef struct {
        logic        is_err;
        logic [7:0]  data;
        int unsigned cyc;
        int unsigned period;
    } ev_t;

    ev_t exp_q[$];
    ev_t obs_q[$];
    ev_t mon_ev;

    uart_rx #(
        .BAUD(1_000_000),
        .FCLK(50_000_000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx          (rx),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_frame_err(rx_frame_err),
        .rx_idle     (rx_idle)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Every strobe-high cycle becomes one observed event
    always @(negedge clk) begin
        if (!rst && (rx_valid || rx_frame_err)) begin
            mon_ev.is_err = rx_frame_err;
            mon_ev.data   = rx_data;
            mon_ev.cyc    = cyc;
            mon_ev.period = 0;
            obs_q.push_back(mon_ev);
            check("strobe_excl", 32'(rx_valid & rx_frame_err), 32'd0);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int unsigned n);
        if (n == 0) return;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic gap(input int unsigned n);
        rx = 1'b1;
        tick(n);
    endtask

    // One full frame; the model records what the receiver must report for it
    task automatic send_frame(input logic [7:0] d, input logic stop, input int unsigned per);
        ev_t e;
        e.is_err = ~stop;
        e.period = per;
        e.cyc    = cyc;
        rx = 1'b0;
        tick(per);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            tick(per);
        end
        rx = stop;
        tick(per);
        if (stop) last_good = d;
        e.data = last_good;
        exp_q.push_back(e);
    endtask

    task automatic settle_and_compare(input string tag);
        ev_t o, e;
        int  d;
        repeat (2 * CBIT) @(posedge clk);
        #1;
        check({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            check({tag, "_kind"}, 32'(o.is_err), 32'(e.is_err));
            check({tag, "_data"}, 32'(o.data), 32'(e.data));
            if (e.period == CBIT) begin
                d = int'(o.cyc) - int'(e.cyc);
                check({tag, "_lat"}, 32'(d), (d >= int'(LAT) - 1 && d <= int'(LAT) + 1) ? 32'(d) : 32'(LAT));
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int waited;
        int d;
        logic [7:0] pd;
        logic [7:0] rd;
        logic       rs;
        int unsigned per;

        rst = 1'b1;
        rx  = 1'b1;
        tick(3);
        check("rst_idle",  32'(rx_idle),      32'd1);
        check("rst_valid", 32'(rx_valid),     32'd0);
        check("rst_err",   32'(rx_frame_err), 32'd0);
        check("rst_data",  32'(rx_data),      32'd0);
        rst = 1'b0;
        tick(5);

        send_frame(8'hFF, 1'b1, CBIT); gap(CBIT);
        send_frame(8'h00, 1'b1, CBIT); gap(CBIT);
        send_frame(8'hA5, 1'b1, CBIT); gap(CBIT);
        send_frame(8'h5A, 1'b1, CBIT); gap(CBIT);
        settle_and_compare("basic");

        // Short low pulse must not produce a frame
        rx = 1'b0;
        tick(10);
        rx = 1'b1;
        waited = 0;
        while (!rx_idle && waited < 30) begin
            tick(1);
            waited++;
        end
        check("glitch_idle", 32'(rx_idle), 32'd1);
        settle_and_compare("glitch");

        send_frame(8'h5A, 1'b1, CBIT); gap(CBIT);
        send_frame(8'h3C, 1'b0, CBIT);
        tick(3 * CBIT);
        check("break_idle", 32'(rx_idle), 32'd1);
        check("ferr_hold",  32'(rx_data), 32'(last_good));
        settle_and_compare("ferr");
        gap(CBIT);
        send_frame(8'hC3, 1'b1, CBIT); gap(CBIT);
        settle_and_compare("after_break");

        // Reset in the middle of data bit 3
        pd = 8'h6B;
        rx = 1'b0;
        tick(CBIT);
        for (int i = 0; i < 3; i++) begin
            rx = pd[i];
            tick(CBIT);
        end
        rx = pd[3];
        tick(CBIT / 2);
        rx  = 1'b1;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        last_good = 8'h00;
        check("midrst_idle", 32'(rx_idle), 32'd1);
        check("midrst_data", 32'(rx_data), 32'(last_good));
        gap(2 * CBIT);
        send_frame(8'h81, 1'b1, CBIT); gap(CBIT);
        settle_and_compare("midrst");

        send_frame(8'h12, 1'b1, CBIT);
        send_frame(8'h34, 1'b1, CBIT);
        gap(CBIT);
        check("b2b_count", 32'(obs_q.size()), 32'd2);
        if (obs_q.size() >= 2) begin
            d = int'(obs_q[1].cyc) - int'(obs_q[0].cyc);
            check("b2b_gap", 32'(d), (d >= int'(10 * CBIT) - 1 && d <= int'(10 * CBIT) + 1) ? 32'(d) : 32'(10 * CBIT));
        end
        settle_and_compare("b2b");

        send_frame(8'h55, 1'b1, 49); gap(CBIT);
        send_frame(8'hAA, 1'b1, 51); gap(CBIT);
        send_frame(8'h55, 1'b1, 51);
        send_frame(8'hAA, 1'b1, 49); gap(CBIT);
        settle_and_compare("skew");

        for (int n = 0; n < 24; n++) begin
            per = 49 + $urandom_range(0, 2);
            rd  = 8'($urandom);
            rs  = ($urandom_range(0, 4) != 0);
            send_frame(rd, rs, per);
            if (!rs) gap(CBIT + $urandom_range(0, CBIT));
            else     gap($urandom_range(0, CBIT));
        end
        gap(CBIT);
        settle_and_compare("rand");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
